// File: rtl/ring_sched.sv
`default_nettype none
// ============================================================================
// Module   : ring_sched
// Purpose  : Measurement sequencer for the ring-oscillator frequency display.
//            Walks the ten ring select codes (or repeats one in manual mode).
//            For each code it settles the ring, opens a counting gate,
//            strobes the result and holds it on the display.
// Revision : 1.0  initial release
// ============================================================================
module ring_sched #(
    parameter int SETTLE = 256,
    parameter int GATE   = 10_000,
    parameter int HOLD   = 2_000_000,
    parameter int TW     = 24
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_auto,
    input  logic       i_step,
    input  logic       i_pause,
    output logic [5:0] o_sel,
    output logic [3:0] o_idx,
    output logic       o_ring_en,
    output logic       o_cnt_clr,
    output logic       o_gate,
    output logic       o_latch,
    output logic       o_busy
);

    typedef enum logic [1:0] {
        S_SETTLE = 2'd0,
        S_GATE   = 2'd1,
        S_LATCH  = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    localparam logic [TW-1:0] c_SETTLE_LAST = TW'(SETTLE - 1);
    localparam logic [TW-1:0] c_GATE_LAST   = TW'(GATE - 1);
    localparam logic [TW-1:0] c_HOLD_LAST   = TW'(HOLD - 1);
    localparam logic [TW-1:0] c_TIMER_ONE   = TW'(1);

    // Gray-like select table: adjacent entries differ in exactly one bit.
    function automatic logic [5:0] f_code(input logic [3:0] idx);
        logic [5:0] code;
        case (idx)
            4'd0:    code = 6'b000001;
            4'd1:    code = 6'b000011;
            4'd2:    code = 6'b000010;
            4'd3:    code = 6'b000110;
            4'd4:    code = 6'b000100;
            4'd5:    code = 6'b001100;
            4'd6:    code = 6'b001000;
            4'd7:    code = 6'b011000;
            4'd8:    code = 6'b010000;
            4'd9:    code = 6'b110000;
            default: code = 6'b000001;
        endcase
        return code;
    endfunction

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_idx;
    logic [3:0]    w_idx_nxt;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_nxt;
    logic          r_flag;
    logic          w_flag_nxt;
    logic          r_step_d;
    logic          w_rise;
    logic          w_consume;

    logic [5:0]    r_sel;
    logic          r_ring_en;
    logic          r_cnt_clr;
    logic          r_gate;
    logic          r_latch;
    logic          r_busy;

    // Next-state, index, timer and step-flag decision.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_timer_nxt = r_timer + c_TIMER_ONE;
        w_consume   = 1'b0;
        w_rise      = i_step & ~r_step_d;

        case (r_state)
            S_SETTLE: begin
                if (r_timer == c_SETTLE_LAST) begin
                    w_state_nxt = S_GATE;
                    w_timer_nxt = '0;
                end
            end
            S_GATE: begin
                if (r_timer == c_GATE_LAST) begin
                    w_state_nxt = S_LATCH;
                    w_timer_nxt = '0;
                end
            end
            S_LATCH: begin
                w_state_nxt = S_HOLD;
                w_timer_nxt = '0;
            end
            S_HOLD: begin
                // A pending step aborts the hold even while paused.
                if (r_flag || (!i_pause && (r_timer == c_HOLD_LAST))) begin
                    w_state_nxt = S_SETTLE;
                    w_timer_nxt = '0;
                    w_consume   = r_flag;
                    if (i_auto || r_flag) begin
                        w_idx_nxt = (r_idx == 4'd9) ? 4'd0 : (r_idx + 4'd1);
                    end
                end else if (i_pause) begin
                    w_timer_nxt = r_timer;
                end
            end
            default: begin
                w_state_nxt = S_SETTLE;
                w_timer_nxt = '0;
            end
        endcase

        // Auto mode discards step requests; a new edge wins over consumption.
        if (i_auto) begin
            w_flag_nxt = 1'b0;
        end else if (w_rise) begin
            w_flag_nxt = 1'b1;
        end else if (w_consume) begin
            w_flag_nxt = 1'b0;
        end else begin
            w_flag_nxt = r_flag;
        end
    end

    // State, timer, index and step tracking registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_SETTLE;
            r_idx    <= 4'd0;
            r_timer  <= '0;
            r_flag   <= 1'b0;
            r_step_d <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_timer  <= w_timer_nxt;
            r_flag   <= w_flag_nxt;
            r_step_d <= i_step;
        end
    end

    // Outputs registered from the next state so they move with the state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sel     <= 6'b000001;
            r_ring_en <= 1'b1;
            r_cnt_clr <= 1'b1;
            r_gate    <= 1'b0;
            r_latch   <= 1'b0;
            r_busy    <= 1'b1;
        end else begin
            r_sel     <= f_code(w_idx_nxt);
            r_ring_en <= (w_state_nxt != S_HOLD);
            r_cnt_clr <= (w_state_nxt == S_SETTLE);
            r_gate    <= (w_state_nxt == S_GATE);
            r_latch   <= (w_state_nxt == S_LATCH);
            r_busy    <= (w_state_nxt != S_HOLD);
        end
    end

    assign o_sel     = r_sel;
    assign o_idx     = r_idx;
    assign o_ring_en = r_ring_en;
    assign o_cnt_clr = r_cnt_clr;
    assign o_gate    = r_gate;
    assign o_latch   = r_latch;
    assign o_busy    = r_busy;

endmodule
`default_nettype wire
